pb_debounce: RTL and testbench

Pushbutton conditioner that sits directly upstream of the reset synchronizer and the user-logic button inputs. It takes a raw, bouncing, asynchronous pushbutton signal and double-flop synchronizes it. It then accepts a level change only after the signal has held the new value for a programmable number of consecutive clocks. Outputs are a clean level, which drives the synchronizer's asynchronous reset input, and single-cycle press/release strobes.

---
 rtl/pb_debounce.sv | 124 ++++++++++++
 tb/tb_pb_debounce.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce.sv
// Pushbutton debouncer: double-flop synchronizer followed by a stable-count
// FSM that emits a clean level and one-cycle press/release strobes.
module pb_debounce #(
    parameter int unsigned STABLE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_in,
    output logic pb_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          w_level_nxt;
    logic          r_press;
    logic          w_press_nxt;
    logic          r_release;
    logic          w_release_nxt;
    logic          w_s;

    // pb_in is asynchronous; only the second flop's output is ever observed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pb_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Count only leaves zero while the candidate differs; every exit clears it
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;

        case (r_state)
            LOW: begin
                w_level_nxt = 1'b0;
                if (w_s) begin
                    w_state_nxt = RISE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            RISE_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = LOW;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HIGH;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HIGH: begin
                w_level_nxt = 1'b1;
                if (!w_s) begin
                    w_state_nxt = FALL_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            FALL_WAIT: begin
                if (w_s) begin
                    w_state_nxt = HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = LOW;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = LOW;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign pb_level      = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

endmodule

// File: tb/tb_pb_debounce.sv
// Scoreboard bench for pb_debounce with STABLE_CYCLES=4: stimulus queues
// expected strobes (kind + edge number), a monitor pops them as strobes appear.
module tb_pb_debounce;

    localparam int unsigned SC = 4;
    localparam int LAT = 1 + SC + 1;

    typedef struct {
        bit is_press;
        int cyc;
    } evt_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pb_in = 1'b0;
    logic pb_level;
    logic press_pulse;
    logic release_pulse;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    evt_t exp_q[$];

    pb_debounce #(.STABLE_CYCLES(SC)) dut (
        .clk          (clk),
        .reset        (reset),
        .pb_in        (pb_in),
        .pb_level     (pb_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset && (press_pulse === 1'b1 || release_pulse === 1'b1)) begin
            total++;
            if (press_pulse && release_pulse) begin
                bad++;
                $display("FAIL both_strobes: press=1 release=1 at cycle %0d", cyc);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: press=%b release=%b at cycle %0d, none expected",
                         press_pulse, release_pulse, cyc);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                if (press_pulse !== logic'(e.is_press)) begin
                    bad++;
                    $display("FAIL strobe_kind: press=%b expected press=%b at cycle %0d",
                             press_pulse, e.is_press, cyc);
                end
                total++;
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL strobe_cycle: got cycle %0d expected %0d", cyc, e.cyc);
                end
                total++;
                if (pb_level !== logic'(e.is_press)) begin
                    bad++;
                    $display("FAIL level_at_strobe: got %b expected %b at cycle %0d",
                             pb_level, e.is_press, cyc);
                end
            end
        end
    end

    task automatic drive(input logic v);
        @(negedge clk);
        pb_in = v;
    endtask

    // Drive a held level and expect the matching strobe LAT edges later
    task automatic drive_expect(input logic v);
        evt_t e;
        @(negedge clk);
        pb_in = v;
        e.is_press = v;
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_reset_expect_press();
        evt_t e;
        @(negedge clk);
        reset = 1'b0;
        e.is_press = 1'b1;
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
    endtask

    logic bounce_vec [9];

    initial begin
        bounce_vec = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset with button held: outputs clear immediately and stay clear
        pb_in = 1'b1;
        idle(2);
        #2 reset = 1'b1;
        #1;
        check("reset_level_imm", pb_level, 1'b0);
        check("reset_press_imm", press_pulse, 1'b0);
        check("reset_release_imm", release_pulse, 1'b0);
        idle(3);
        check("reset_level_held", pb_level, 1'b0);
        check("reset_press_held", press_pulse, 1'b0);
        check("reset_release_held", release_pulse, 1'b0);
        release_reset_expect_press();
        idle(LAT + 3);
        check("level_after_reset", pb_level, 1'b1);

        // Release, then clean press, then release again
        drive_expect(1'b0);
        idle(LAT + 3);
        check("level_after_release", pb_level, 1'b0);
        drive_expect(1'b1);
        idle(LAT + 3);
        check("level_after_press", pb_level, 1'b1);
        drive_expect(1'b0);
        idle(LAT + 3);
        check("level_low_again", pb_level, 1'b0);

        // Bounce: only the final run of four highs counts
        for (int i = 0; i < 9; i++) begin
            if (i == 5) drive_expect(bounce_vec[i]);
            else        drive(bounce_vec[i]);
        end
        idle(LAT + 3);
        check("level_after_bounce", pb_level, 1'b1);
        drive_expect(1'b0);
        idle(LAT + 3);
        check("level_after_bounce_release", pb_level, 1'b0);

        // Glitch one cycle short of the threshold
        drive(1'b1);
        idle(SC - 2);
        drive(1'b0);
        idle(LAT + 4);
        check("level_after_glitch", pb_level, 1'b0);

        // Reset in RISE_WAIT with cnt=2, then full latency again
        drive(1'b1);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_level", pb_level, 1'b0);
        check("midreset_press", press_pulse, 1'b0);
        idle(2);
        release_reset_expect_press();
        idle(LAT - 1);
        check("midreset_not_early", pb_level, 1'b0);
        idle(4);
        check("level_after_midreset", pb_level, 1'b1);

        // Bounded drain of any outstanding expected strobe
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_strobes: %0d still pending, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
